// File: rtl/exec_pkg.sv
// Shared encodings for the EX stage: ALU op codes, MDU op codes, forwarding selects, MDU states.
package exec_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_LUI  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MFHI  = 3'd5;
  localparam logic [2:0] MD_MFLO  = 3'd6;

  localparam logic [1:0] FW_NONE = 2'b00;
  localparam logic [1:0] FW_MEM  = 2'b10;
  localparam logic [1:0] FW_WB   = 2'b01;

  typedef enum logic [1:0] {MDU_IDLE, MDU_RUN, MDU_FIX} mdu_state_e;
endpackage

// File: rtl/mul_div_unit.sv
// Iterative 1-bit/cycle multiply (shift-add) and restoring divide on magnitudes; owns HI/LO.
// EXEC_MDU_EARLY_OUT_EN: multiplies leave RUN once the remaining multiplier bits are zero.
module mul_div_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  mdu_state_e          state;
  logic [5:0]          cnt;
  logic                isDiv, negQ, negR, divZero;
  // mul: acc = product, mcand = shifted multiplicand, shReg = multiplier
  // div: acc[DATA_W-1:0] = remainder, mcand[DATA_W-1:0] = divisor, shReg = dividend/quotient
  logic [2*DATA_W-1:0] acc, mcand, mulSum;
  logic [DATA_W-1:0]   shReg, rawA, diff, magA, magB;
  logic [DATA_W:0]     remShift;
  logic                ge, sgnA, sgnB, isSigned, startDiv;

  assign busy     = (state != MDU_IDLE);
  assign isSigned = (op == MD_MULT) || (op == MD_DIV);
  assign startDiv = (op == MD_DIV) || (op == MD_DIVU);
  assign sgnA     = isSigned & a[DATA_W-1];
  assign sgnB     = isSigned & b[DATA_W-1];
  assign magA     = sgnA ? -a : a;
  assign magB     = sgnB ? -b : b;
  assign mulSum   = shReg[0] ? acc + mcand : acc;
  assign remShift = {acc[DATA_W-1:0], shReg[DATA_W-1]};
  assign ge       = remShift >= {1'b0, mcand[DATA_W-1:0]};
  assign diff     = remShift[DATA_W-1:0] - mcand[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MDU_IDLE; cnt <= '0; hi <= '0; lo <= '0;
      acc <= '0; mcand <= '0; shReg <= '0; rawA <= '0;
      isDiv <= 1'b0; negQ <= 1'b0; negR <= 1'b0; divZero <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: if (start) begin
          isDiv   <= startDiv;
          negQ    <= sgnA ^ sgnB;
          negR    <= sgnA;
          divZero <= (b == '0);
          rawA    <= a;
          cnt     <= '0;
          acc     <= '0;
          mcand   <= startDiv ? {{DATA_W{1'b0}}, magB} : {{DATA_W{1'b0}}, magA};
          shReg   <= startDiv ? magA : magB;
          state   <= MDU_RUN;
        end
        MDU_RUN: begin
          cnt <= cnt + 6'd1;
          if (isDiv) begin
            acc[DATA_W-1:0] <= ge ? diff : remShift[DATA_W-1:0];
            shReg           <= {shReg[DATA_W-2:0], ge};
          end else begin
            acc   <= mulSum;
            mcand <= mcand << 1;
            shReg <= shReg >> 1;
          end
          if (cnt == 6'(DATA_W-1)) state <= MDU_FIX;
`ifdef EXEC_MDU_EARLY_OUT_EN
          else if (!isDiv && (shReg >> 1) == '0) state <= MDU_FIX;
`endif
        end
        MDU_FIX: begin
          if (!isDiv) begin
            {hi, lo} <= negQ ? -acc : acc;
          end else if (divZero) begin
            hi <= rawA;
            lo <= '1;
          end else begin
            lo <= negQ ? -shReg : shReg;
            hi <= negR ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
          end
          state <= MDU_IDLE;
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: forwarding muxes, ALU, MDU stall/operand hold and the EX/MEM register.
// EXEC_MDU_EARLY_OUT_EN (in mul_div_unit) shortens multiply busy time.
module execute_stage
  import exec_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        fw_alu1,
  input  logic [1:0]        fw_alu2,
  input  logic [DATA_W-1:0] rs_dataE,
  input  logic [DATA_W-1:0] rt_dataE,
  input  logic [DATA_W-1:0] imm_extE,
  input  logic              alu_srcE,
  input  logic [3:0]        alu_ctrlE,
  input  logic [2:0]        md_opE,
  input  logic              reg_writeE,
  input  logic              mem_writeE,
  input  logic              mem_to_regE,
  input  logic [ADDR_W-1:0] write_reg_addrE,
  input  logic [DATA_W-1:0] result_W,
  output logic              stallE,
  output logic [DATA_W-1:0] alu_resultM,
  output logic [DATA_W-1:0] write_dataM,
  output logic [ADDR_W-1:0] write_reg_addrM,
  output logic              reg_writeM,
  output logic              mem_writeM,
  output logic              mem_to_regM
);
  logic [DATA_W-1:0] srcA, srcB, opA, rtVal, opB, aluOut, hi, lo, holdA, holdB;
  logic [4:0]        shamt;
  logic              holdVld, busy, mduStart;

  function automatic logic [DATA_W-1:0] fwdSel(input logic [1:0] sel,
      input logic [DATA_W-1:0] idex, input logic [DATA_W-1:0] mem, input logic [DATA_W-1:0] wb);
    case (sel)
      FW_MEM:  return mem;
      FW_WB:   return wb;
      default: return idex;
    endcase
  endfunction

  assign srcA  = fwdSel(fw_alu1, rs_dataE, alu_resultM, result_W);
  assign srcB  = fwdSel(fw_alu2, rt_dataE, alu_resultM, result_W);
  // M/W producers drain while stalled, so the stalled instruction uses its captured operands
  assign opA   = holdVld ? holdA : srcA;
  assign rtVal = holdVld ? holdB : srcB;
  assign opB   = alu_srcE ? imm_extE : rtVal;
  assign shamt = imm_extE[10:6];

  assign stallE   = busy && (md_opE != MD_NONE);
  assign mduStart = !stallE && (md_opE inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU});

  always_comb begin
    aluOut = '0;
    case (alu_ctrlE)
      ALU_AND:  aluOut = opA & opB;
      ALU_OR:   aluOut = opA | opB;
      ALU_ADD:  aluOut = opA + opB;
      ALU_XOR:  aluOut = opA ^ opB;
      ALU_LUI:  aluOut = opB << 16;
      ALU_SUB:  aluOut = opA - opB;
      ALU_SLT:  aluOut = {{(DATA_W-1){1'b0}}, $signed(opA) < $signed(opB)};
      ALU_SLTU: aluOut = {{(DATA_W-1){1'b0}}, opA < opB};
      ALU_NOR:  aluOut = ~(opA | opB);
      ALU_SLL:  aluOut = rtVal << shamt;
      ALU_SRL:  aluOut = rtVal >> shamt;
      ALU_SRA:  aluOut = $signed(rtVal) >>> shamt;
      default:  aluOut = '0;
    endcase
  end

  mul_div_unit #(.DATA_W(DATA_W)) uMdu (
    .clk(clk), .reset(reset), .start(mduStart), .op(md_opE),
    .a(opA), .b(rtVal), .busy(busy), .hi(hi), .lo(lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      holdVld <= 1'b0; holdA <= '0; holdB <= '0;
    end else if (stallE && !holdVld) begin
      holdVld <= 1'b1; holdA <= srcA; holdB <= srcB;
    end else if (!stallE) begin
      holdVld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || stallE) begin
      alu_resultM <= '0; write_dataM <= '0; write_reg_addrM <= '0;
      reg_writeM <= 1'b0; mem_writeM <= 1'b0; mem_to_regM <= 1'b0;
    end else begin
      alu_resultM     <= (md_opE == MD_MFHI) ? hi : (md_opE == MD_MFLO) ? lo : aluOut;
      write_dataM     <= rtVal;
      write_reg_addrM <= write_reg_addrE;
      reg_writeM      <= reg_writeE;
      mem_writeM      <= mem_writeE;
      mem_to_regM     <= mem_to_regE;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// Randomized scoreboard bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] fw_alu1 = '0, fw_alu2 = '0;
  logic [31:0] rs_dataE = '0, rt_dataE = '0, imm_extE = '0, result_W = '0;
  logic alu_srcE = 1'b0, reg_writeE = 1'b0, mem_writeE = 1'b0, mem_to_regE = 1'b0;
  logic [3:0] alu_ctrlE = '0;
  logic [2:0] md_opE = '0;
  logic [4:0] write_reg_addrE = '0;
  logic stallE, reg_writeM, mem_writeM, mem_to_regM;
  logic [31:0] alu_resultM, write_dataM;
  logic [4:0] write_reg_addrM;

  execute_stage dut (
    .clk(clk), .reset(reset), .fw_alu1(fw_alu1), .fw_alu2(fw_alu2),
    .rs_dataE(rs_dataE), .rt_dataE(rt_dataE), .imm_extE(imm_extE), .alu_srcE(alu_srcE),
    .alu_ctrlE(alu_ctrlE), .md_opE(md_opE), .reg_writeE(reg_writeE), .mem_writeE(mem_writeE),
    .mem_to_regE(mem_to_regE), .write_reg_addrE(write_reg_addrE), .result_W(result_W),
    .stallE(stallE), .alu_resultM(alu_resultM), .write_dataM(write_dataM),
    .write_reg_addrM(write_reg_addrM), .reg_writeM(reg_writeM), .mem_writeM(mem_writeM),
    .mem_to_regM(mem_to_regM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, wd;
    logic [4:0]  wa;
    logic        rw, mw, m2r;
  } exp_t;

  exp_t exQ[$];
  bit   stallQ[$];
  int   checks = 0, errors = 0;
  bit   monOn = 1'b0;

  // reference model state
  exp_t        mCur;
  int          mBusy = 0;
  logic [31:0] mHi = 0, mLo = 0, pHi = 0, pLo = 0, mHoldA = 0, mHoldB = 0;
  bit          mHoldV = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (monOn) begin
    if (stallQ.size() > 0) check("stallE", 32'(stallE), 32'(stallQ.pop_front()));
    if (exQ.size() > 0) begin
      exp_t e;
      e = exQ.pop_front();
      check("alu_resultM", alu_resultM, e.alu);
      check("write_dataM", write_dataM, e.wd);
      check("write_reg_addrM", 32'(write_reg_addrM), 32'(e.wa));
      check("ctrlM", {29'b0, reg_writeM, mem_writeM, mem_to_regM}, {29'b0, e.rw, e.mw, e.m2r});
    end
  end

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] v);
    if (sel == 2'b10) return mCur.alu;
    if (sel == 2'b01) return result_W;
    return v;
  endfunction

  function automatic logic [31:0] aluRef(input logic [3:0] c, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] rt, input int sh);
    case (c)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a ^ b;
      4'd4: return b * 32'h10000;
      4'd6: return a - b;
      4'd7: return (int'(a) < int'(b)) ? 1 : 0;
      4'd11: return (a < b) ? 1 : 0;
      4'd12: return ~(a | b);
      4'd8: return rt * (32'd1 << sh);
      4'd9: return rt / (32'd1 << sh);
      4'd10: return 32'(int'(rt) >>> sh);
      default: return 0;
    endcase
  endfunction

  // One clock of stimulus: predict stall now and EX/MEM after the edge.
  task automatic cycle(output bit st);
    logic [31:0] a, rtv, b;
    exp_t nx;
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    int dur, k;
    logic [31:0] mag;
    st  = (mBusy > 0) && (md_opE != 0);
    a   = mHoldV ? mHoldA : fwd(fw_alu1, rs_dataE);
    rtv = mHoldV ? mHoldB : fwd(fw_alu2, rt_dataE);
    b   = alu_srcE ? imm_extE : rtv;
    stallQ.push_back(st);
    nx = '{alu: 0, wd: 0, wa: 0, rw: 0, mw: 0, m2r: 0};
    if (!st) begin
      nx.alu = (md_opE == 5) ? mHi : (md_opE == 6) ? mLo : aluRef(alu_ctrlE, a, b, rtv, int'(imm_extE[10:6]));
      nx.wd = rtv; nx.wa = write_reg_addrE;
      nx.rw = reg_writeE; nx.mw = mem_writeE; nx.m2r = mem_to_regE;
    end
    @(posedge clk);
    if (reset) begin
      mBusy = 0; mHi = 0; mLo = 0; mHoldV = 0;
      mCur = '{alu: 0, wd: 0, wa: 0, rw: 0, mw: 0, m2r: 0};
    end else begin
      if (mBusy > 0) begin
        mBusy--;
        if (mBusy == 0) begin mHi = pHi; mLo = pLo; end
      end
      if (!st && md_opE inside {[3'd1:3'd4]}) begin
        sa = longint'(signed'(a)); sb = longint'(signed'(rtv));
        ua = longint'(a); ub = longint'(rtv);
        dur = 33;
        case (md_opE)
          3'd1: begin p = sa * sb; {pHi, pLo} = p; end
          3'd2: begin p = ua * ub; {pHi, pLo} = p; end
          3'd3: if (rtv == 0) begin pHi = a; pLo = '1; end
                else begin q = sa / sb; r = sa % sb; pLo = 32'(q); pHi = 32'(r); end
          default: if (rtv == 0) begin pHi = a; pLo = '1; end
                   else begin pLo = a / rtv; pHi = a % rtv; end
        endcase
`ifdef EXEC_MDU_EARLY_OUT_EN
        if (md_opE <= 2) begin
          mag = (md_opE == 1 && rtv[31]) ? -rtv : rtv;
          k = 1;
          for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
          dur = k + 1;
        end
`endif
        mBusy = dur;
      end
      if (st && !mHoldV) begin mHoldA = a; mHoldB = rtv; mHoldV = 1; end
      else if (!st) mHoldV = 0;
      mCur = nx;
    end
    exQ.push_back(mCur);
    #1;
  endtask

  // Present one instruction and hold it in ID/EX for as long as it stalls.
  task automatic run(input logic [3:0] ctrl, input logic [2:0] md, input logic [31:0] rs,
      input logic [31:0] rt, input logic [31:0] imm, input logic src,
      input logic [1:0] f1, input logic [1:0] f2, output int nStall);
    bit st;
    nStall = 0;
    alu_ctrlE = ctrl; md_opE = md; rs_dataE = rs; rt_dataE = rt; imm_extE = imm;
    alu_srcE = src; fw_alu1 = f1; fw_alu2 = f2;
    reg_writeE = 1'($urandom); mem_writeE = 1'($urandom); mem_to_regE = 1'($urandom);
    write_reg_addrE = 5'($urandom);
    cycle(st);
    while (st) begin
      nStall++;
      if (nStall > 100) begin
        checks++; errors++;
        $display("FAIL stall_timeout: stalled %0d cycles, expected at most 100", nStall);
        return;
      end
      result_W = $urandom; fw_alu1 = 2'($urandom); fw_alu2 = 2'($urandom);
      cycle(st);
    end
  endtask

  int n;
  bit dummy;
  logic [31:0] rr;

  initial begin
    mCur = '{alu: 0, wd: 0, wa: 0, rw: 0, mw: 0, m2r: 0};
    repeat (2) @(posedge clk);
    #1 monOn = 1'b1;
    cycle(dummy);
    cycle(dummy);
    reset = 1'b0;

    // forwarding from M and W into an ADD
    run(4'd2, 3'd0, 32'd2, 32'd3, 0, 0, 2'b00, 2'b00, n);
    check("setup_add", alu_resultM, 32'd5);
    result_W = 32'd7;
    run(4'd2, 3'd0, 32'd100, 32'd200, 0, 0, 2'b10, 2'b01, n);
    check("fwd_add", alu_resultM, 32'd12);

    // MULT -3*7 then MFLO/MFHI
    run(4'd0, 3'd1, -32'sd3, 32'd7, 0, 0, 2'b00, 2'b00, n);
    run(4'd0, 3'd6, 0, 0, 0, 0, 2'b00, 2'b00, n);
    check("mflo_mult", alu_resultM, 32'hFFFFFFEB);
`ifndef EXEC_MDU_EARLY_OUT_EN
    check("mflo_stall_len", 32'(n), 32'd33);
`endif
    run(4'd0, 3'd5, 0, 0, 0, 0, 2'b00, 2'b00, n);
    check("mfhi_mult", alu_resultM, 32'hFFFFFFFF);

    // DIVU 100/7, DIV 9/0
    run(4'd0, 3'd4, 32'd100, 32'd7, 0, 0, 2'b00, 2'b00, n);
    run(4'd0, 3'd5, 0, 0, 0, 0, 2'b00, 2'b00, n);
    check("divu_hi", alu_resultM, 32'd2);
    run(4'd0, 3'd6, 0, 0, 0, 0, 2'b00, 2'b00, n);
    check("divu_lo", alu_resultM, 32'd14);
    run(4'd0, 3'd3, 32'd9, 32'd0, 0, 0, 2'b00, 2'b00, n);
    run(4'd0, 3'd6, 0, 0, 0, 0, 2'b00, 2'b00, n);
    check("div0_lo", alu_resultM, 32'hFFFFFFFF);
    run(4'd0, 3'd5, 0, 0, 0, 0, 2'b00, 2'b00, n);
    check("div0_hi", alu_resultM, 32'd9);

    // DIV with rs forwarded from W, issued while busy; result_W churns during the stall
    run(4'd0, 3'd2, 32'd3, 32'd4, 0, 0, 2'b00, 2'b00, n);
    result_W = 32'd50;
    run(4'd0, 3'd3, 32'd1234, 32'd5, 0, 0, 2'b01, 2'b00, n);
    run(4'd0, 3'd6, 0, 0, 0, 0, 2'b00, 2'b00, n);
    check("held_div_lo", alu_resultM, 32'd10);

    // reset in the middle of RUN
    run(4'd0, 3'd1, 32'd12345, 32'd6789, 0, 0, 2'b00, 2'b00, n);
    repeat (5) run(4'd2, 3'd0, $urandom, $urandom, 0, 0, 2'b00, 2'b00, n);
    reset = 1'b1;
    run(4'd2, 3'd0, 32'd1, 32'd1, 0, 0, 2'b00, 2'b00, n);
    reset = 1'b0;
    check("rst_alu", alu_resultM, 32'd0);
    run(4'd0, 3'd5, 0, 0, 0, 0, 2'b00, 2'b00, n);
    check("rst_hi", alu_resultM, 32'd0);
    check("rst_nostall", 32'(n), 32'd0);
    run(4'd0, 3'd6, 0, 0, 0, 0, 2'b00, 2'b00, n);
    check("rst_lo", alu_resultM, 32'd0);

    // shifts and compares
    run(4'd10, 3'd0, 0, 32'h80000000, 32'h100, 0, 2'b00, 2'b00, n);
    check("sra", alu_resultM, 32'hF8000000);
    run(4'd11, 3'd0, 32'd1, 32'hFFFFFFFF, 0, 0, 2'b00, 2'b00, n);
    check("sltu", alu_resultM, 32'd1);
    run(4'd7, 3'd0, 32'd1, 32'hFFFFFFFF, 0, 0, 2'b00, 2'b00, n);
    check("slt", alu_resultM, 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [2:0] md;
      int r;
      r = $urandom_range(0, 19);
      md = (r < 2) ? 3'($urandom_range(1, 4)) : (r < 4) ? 3'($urandom_range(5, 6)) : 3'd0;
      rr = ($urandom_range(0, 9) == 0) ? 32'd0 :
           ($urandom_range(0, 3) == 0) ? ($urandom & 32'h3FF) : $urandom;
      result_W = $urandom;
      run(4'($urandom_range(0, 15)), md, $urandom, rr, $urandom, 1'($urandom),
          2'($urandom), 2'($urandom), n);
    end
    repeat (3) run(4'd0, 3'd0, 0, 0, 0, 0, 2'b00, 2'b00, n);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline, directly downstream of the forwarding unit.
- Consumes fw_alu1/fw_alu2 to select ALU operands from the ID/EX values, the EX/MEM result or the WB result.
- Contains the ALU, an iterative multiply/divide unit (HI/LO) with a stall handshake, and the EX/MEM pipeline register.
- Drives the reg_writeM/write_reg_addrM signals that the forwarding unit consumes.

Parameters:
DATA_W, 32, datapath width; the MDU is designed for 32 only.
ADDR_W, 5, register address width.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
fw_alu1  in  2  operand A select: 00 rs_dataE, 10 alu_resultM (EX/MEM), 01 result_W
fw_alu2  in  2  operand B select, same encoding, applied to rt
rs_dataE  in  DATA_W  rs value from ID/EX
rt_dataE  in  DATA_W  rt value from ID/EX
imm_extE  in  DATA_W  sign/zero-extended immediate; bits [10:6] = shamt
alu_srcE  in  1  1: ALU B = imm_extE; 0: forwarded rt
alu_ctrlE  in  4  ALU op code
md_opE  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO
reg_writeE, mem_writeE, mem_to_regE  in  1 each  control from ID/EX
write_reg_addrE  in  ADDR_W  destination register
result_W  in  DATA_W  WB-stage result, used for forwarding
stallE  out  1  combinational; upstream holds PC, IF/ID and ID/EX while high
alu_resultM  out  DATA_W  EX/MEM: ALU, HI or LO result
write_dataM  out  DATA_W  EX/MEM: forwarded rt, store data
write_reg_addrM  out  ADDR_W  EX/MEM
reg_writeM, mem_writeM, mem_to_regM  out  1 each  EX/MEM

Behaviour:
- Reset: all EX/MEM outputs 0; HI=LO=0; MDU idle; operand-hold valid = 0; stallE = 0.
- Forwarding mux: encoding 11 is treated as 00.
- Operand B: forwarded rt, replaced by imm_extE when alu_srcE = 1. write_dataM always takes the forwarded rt.
- ALU codes (no overflow trap):
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 LUI (B<<16), 0110 SUB
  - 0111 SLT (signed), 1011 SLTU, 1100 NOR
  - 1000 SLL, 1001 SRL, 1010 SRA: shift B (forwarded rt) by imm_extE[10:6]
  - other codes give 0.
- Normal latency: 1 cycle; EX/MEM loads every cycle when stallE = 0.
- MFHI/MFLO with MDU idle: alu_resultM <= HI or LO; write follows reg_writeE.
- MDU states IDLE, RUN, FIX.
  - IDLE to RUN: a MULT/MULTU/DIV/DIVU is in EX and stallE = 0.
    - Latch the operands; iteration count = 0.
    - The issuing instruction passes to EX/MEM in the same cycle with the given reg_writeE (decode supplies 0).
  - RUN: 32 iterations, 1 bit per cycle.
    - Multiply is shift-add.
    - Divide is restoring, on magnitudes; signed ops use absolute values.
  - RUN to FIX after iteration 32.
  - FIX: apply sign correction and write HI/LO, then return to IDLE.
  - Busy = state is not IDLE, for exactly 33 cycles after the issue edge.
- Divide by zero: same latency; LO = 0xFFFFFFFF, HI = dividend.
- stallE = busy AND md_opE != 0. While stalled:
  - EX/MEM loads a bubble: all three control bits 0, data 0.
  - No new MDU start.
  - HI/LO writes from FIX still occur.
  - The stalled instruction completes in the first cycle with busy = 0.
- Operand hold:
  - On the first stall cycle, latch the post-forwarding A and B into hold registers and set hold-valid.
  - While hold-valid is set, operands come from the hold registers; fw_* are ignored.
  - Clear hold-valid when stallE falls.
  - This is required because forwarded M/W producers drain during the stall.
- Back-to-back MULT then MFLO: MFLO stalls 33 cycles, then reads the new LO.
- Reset mid-operation: MDU aborts to IDLE, HI/LO = 0, any stall drops the next cycle.

Optional Feature:
- Macro EXEC_MDU_EARLY_OUT_EN.
- Defined: MULT/MULTU leaves RUN as soon as the remaining multiplier bits are all zero (minimum 1 RUN cycle). Divide is unchanged. Results are identical; only busy duration shrinks.
- Undefined: fixed 33-cycle busy for all MDU ops.

Decomposition:
- Package exec_pkg holds:
  - ALU_* codes
  - MD_* op codes
  - FW_NONE=2'b00, FW_MEM=2'b10, FW_WB=2'b01
  - MDU state enum
- Sub-module mul_div_unit: inputs start, op, a, b; outputs busy, hi, lo. It owns HI/LO and the FSM.
- Forwarding muxes, ALU, stall/hold logic and the EX/MEM register stay in execute_stage.

Test Plan:
1. ADD with fw_alu1=10 (alu_resultM=5) and fw_alu2=01 (result_W=7) -> next-cycle alu_resultM=12, reg_writeM follows reg_writeE.
2. MULT rs=-3, rt=7, then MFLO next cycle -> stallE high 33 cycles with bubbles (reg_writeM=0); MFLO then yields 0xFFFFFFEB; MFHI yields 0xFFFFFFFF.
3. DIVU 100/7 with MFHI following -> HI=2, LO=14; DIV by 0 with rs=9 -> LO=0xFFFFFFFF, HI=9.
4. DIV whose rs is forwarded from W (fw_alu1=01), issued while MDU busy -> stall; result_W changes during the stall; final quotient uses the held value.
5. Reset asserted mid-RUN -> next cycle stallE=0, HI=LO=0, all EX/MEM outputs 0.
6. SRA with shamt=4 on rt=0x80000000 -> 0xF8000000; SLTU(1, 0xFFFFFFFF) -> 1; SLT(1, 0xFFFFFFFF) -> 0.
